// File: rtl/gf2m_409_trinomial_reducer.sv
// Iterative reduction of a 2*M-bit carry-less product modulo x^M + x^K + 1, FOLD_W bits per cycle.
// Optional early exit when the upper half is already clear: define GF409_REDUCE_SKIP_EN.
module gf2m_409_trinomial_reducer #(
   parameter int M      = 409,
   parameter int K      = 87,
   parameter int FOLD_W = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*M-1:0] in_c,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [M-1:0]   out_r,
   output logic           busy
);

   localparam int NFOLD = (M + FOLD_W - 1) / FOLD_W;
   localparam int PW    = $clog2(2*M);
   localparam int CW    = $clog2(NFOLD + 1);

   typedef enum logic [1:0] {S_IDLE, S_FOLD, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [2*M-1:0] acc, acc_fold;
   logic [PW-1:0]  ptr;
   logic [CW-1:0]  cnt;
   logic           last_fold, top_zero, fold_end, accept;

   // Clear acc[ptr -: FOLD_W] (never below bit M) and fold each set bit k onto k-M and k-M+K.
   // Folded bits always land below the chunk, so the whole chunk can be processed at once.
   function automatic logic [2*M-1:0] fold_chunk(input logic [2*M-1:0] a, input logic [PW-1:0] p);
      int             hi, lo, n;
      logic [2*M-1:0] mask, chunk;
      hi = int'(p);
      lo = hi - FOLD_W + 1;
      if (lo < M) lo = M;
      n = hi - lo + 1;
      mask  = {(2*M){1'b1}} >> (2*M - n);
      chunk = (a >> lo) & mask;
      return a ^ (chunk << lo) ^ (chunk << (lo - M)) ^ (chunk << (lo - M + K));
   endfunction

   assign acc_fold  = fold_chunk(acc, ptr);
   assign last_fold = (cnt == CW'(NFOLD - 1));

`ifdef GF409_REDUCE_SKIP_EN
   assign top_zero = (acc[2*M-1:M] == '0);
`else
   assign top_zero = 1'b0;
`endif

   // With a clear upper half the fold is a no-op, so acc_fold low bits equal acc low bits.
   assign fold_end  = last_fold | top_zero;
   assign in_ready  = (state == S_IDLE) & rst;
   assign accept    = in_valid & in_ready;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)    state_nxt = S_FOLD;
         S_FOLD:  if (fold_end)  state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         ptr       <= '0;
         cnt       <= '0;
         out_r     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  acc <= in_c;
                  ptr <= PW'(2*M - 1);
                  cnt <= '0;
               end
            end
            S_FOLD: begin
               acc <= acc_fold;
               ptr <= ptr - PW'(FOLD_W);
               cnt <= cnt + 1'b1;
               if (fold_end) begin
                  out_r     <= acc_fold[M-1:0];
                  out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2m_409_trinomial_reducer.sv
// Randomised self-checking bench: long-division reference model, queue scoreboard, handshake monitor.
module tb_gf2m_409_trinomial_reducer;

   localparam int M      = 409;
   localparam int K      = 87;
   localparam int FOLD_W = 64;
   localparam int NFOLD  = 7;
   localparam int NRAND  = 1500;

   logic           clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2*M-1:0] in_c;
   logic [M-1:0]   out_r;

   typedef struct {
      logic [M-1:0] r;
      int           lat;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   rdy_mode = 2;
   bit   mon_en   = 0;

   gf2m_409_trinomial_reducer #(.M(M), .K(K), .FOLD_W(FOLD_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .busy(busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk_vec(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Textbook polynomial long division, one bit at a time from the top.
   function automatic logic [M-1:0] ref_mod(input logic [2*M-1:0] v, output int lat);
      logic [2*M-1:0] a;
      int lowk;
      a = v;
      lowk = -1;
      for (int k = 2*M-1; k >= M; k--) begin
         if (a[k]) begin
            a[k] = 1'b0;
            a[k-M] = ~a[k-M];
            a[k-M+K] = ~a[k-M+K];
            lowk = k;
         end
      end
`ifdef GF409_REDUCE_SKIP_EN
      if (lowk < 0) lat = 1;
      else begin
         lat = (2*M-1-lowk) / FOLD_W + 2;
         if (lat > NFOLD) lat = NFOLD;
      end
`else
      lat = NFOLD;
`endif
      return a[M-1:0];
   endfunction

   function automatic logic [2*M-1:0] rand_vec(input int mode);
      logic [2*M-1:0] v;
      v = '0;
      if (mode == 2) begin
         for (int j = 0; j < 4; j++) v[$urandom_range(M, 2*M-1)] = 1'b1;
      end else begin
         for (int i = 0; i < 2*M; i++) v[i] = 1'($urandom_range(0, 1));
         if (mode == 1) v[2*M-1:M] = '0;
      end
      return v;
   endfunction

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pending = a product has been accepted and not yet handed out.
   initial begin : mon
      bit pending, seen_valid;
      int acc_idx;
      pending = 0; seen_valid = 0; acc_idx = 0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst) begin
            pending = 0;
            seen_valid = 0;
            continue;
         end
         chk_int("busy", int'(busy), int'(pending));
         chk_int("in_ready", int'(in_ready), int'(!pending));
         if (out_valid) begin
            if (!pending || expq.size() == 0) begin
               chk_int("spurious_out_valid", 1, 0);
            end else begin
               if (!seen_valid) begin
                  chk_int("latency", cyc - acc_idx, expq[0].lat);
                  seen_valid = 1;
               end
               chk_vec("out_r", out_r, expq[0].r);
               if (out_ready) begin
                  void'(expq.pop_front());
                  pending = 0;
                  seen_valid = 0;
               end
            end
         end else if (pending && (cyc - acc_idx > 60)) begin
            chk_int("timeout_out_valid", cyc - acc_idx, expq.size() > 0 ? expq[0].lat : 0);
            if (expq.size() > 0) void'(expq.pop_front());
            pending = 0;
         end
         if (in_valid && in_ready) begin
            pending = 1;
            acc_idx = cyc + 1;
         end
      end
   end

   // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
   task automatic send(input logic [2*M-1:0] v);
      exp_t e;
      int   lat, guard;
      e.r = ref_mod(v, lat);
      e.lat = lat;
      expq.push_back(e);
      in_c = v;
      in_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) chk_int("accept_timeout", guard, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_c = ~v;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while ((expq.size() != 0 || busy) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) chk_int("idle_timeout", guard, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2*M-1:0] v409, v817, vzero, vlow, v;
      logic [M-1:0]   e, r;
      int             lat, guard;

      rst = 1'b0; in_valid = 1'b0; in_c = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_int("rst_out_valid", int'(out_valid), 0);
      chk_vec("rst_out_r", out_r, '0);
      chk_int("rst_busy", int'(busy), 0);
      rst = 1'b1;
      @(negedge clk);
      chk_int("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      mon_en = 1;

      v409 = '0; v409[409] = 1'b1;
      v817 = '0; v817[817] = 1'b1;
      vzero = '0;
      vlow = '0; vlow[M-1:0] = {M{1'b1}};

      e = '0; e[87] = 1'b1; e[0] = 1'b1;
      r = ref_mod(v409, lat);
      chk_vec("model_x409", r, e);
      chk_int("model_x409_lat", lat, 7);
      e = '0; e[408] = 1'b1; e[173] = 1'b1; e[86] = 1'b1;
      r = ref_mod(v817, lat);
      chk_vec("model_x817", r, e);
      chk_int("model_x817_lat", lat, 7);
      r = ref_mod(vzero, lat);
      chk_vec("model_zero", r, '0);
`ifdef GF409_REDUCE_SKIP_EN
      chk_int("model_zero_lat", lat, 1);
`else
      chk_int("model_zero_lat", lat, 7);
`endif
      r = ref_mod(vlow, lat);
      chk_vec("model_low_ones", r, {M{1'b1}});

      send(v409);
      send(v817);
      send(vzero);
      send(vlow);
      wait_idle();

      // Reset in the middle of a fold; out_r currently holds the all-ones result.
      mon_en = 0;
      rdy_mode = 2;
      in_c = v409;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk_int("pre_abort_busy", int'(busy), 1);
      @(posedge clk);
      rst = 1'b0;
      #1;
      chk_int("abort_out_valid", int'(out_valid), 0);
      chk_vec("abort_out_r", out_r, '0);
      chk_int("abort_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1;
      send(v409);
      wait_idle();

      // Backpressure in DONE: outputs frozen, new input refused.
      rdy_mode = 1;
      @(posedge clk);
      #1;
      v = rand_vec(0);
      e = ref_mod(v, lat);
      send(v);
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk_int("bp_reach_done", int'(out_valid), 1);
      @(posedge clk);
      #1;
      in_c = rand_vec(0);
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk_int("bp_out_valid", int'(out_valid), 1);
         chk_vec("bp_out_r", out_r, e);
         chk_int("bp_in_ready", int'(in_ready), 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rdy_mode = 2;
      wait_idle();
      @(negedge clk);
      chk_int("bp_after_busy", int'(busy), 0);
      chk_int("bp_after_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;

      rdy_mode = 0;
      for (int n = 0; n < NRAND; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send(rand_vec(n % 3));
      end
      wait_idle();
      chk_int("queue_drained", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
